// File: rtl/mem_arbiter_pkg.sv
// Shared configuration for the instruction/data memory arbiter.
// State encodings, access-size codes and reset polarity constants.
package mem_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IF_RD  = 3'd1,
        MEM_RD = 3'd2,
        MEM_WR = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [1:0] LEN_B = 2'd0;
    localparam logic [1:0] LEN_H = 2'd1;
    localparam logic [1:0] LEN_R = 2'd2;
    localparam logic [1:0] LEN_W = 2'd3;

    localparam logic ResetEnable  = 1'b0;
    localparam logic ResetDisable = 1'b1;

    // Byte count of an access; the reserved code behaves as a word.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        logic [2:0] n;
        case (len)
            LEN_B:   n = 3'd1;
            LEN_H:   n = 3'd2;
            LEN_R:   n = 3'd4;
            LEN_W:   n = 3'd4;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    // Keeps only the low n bytes of an assembled load word.
    function automatic logic [31:0] len_mask(input logic [2:0] n);
        logic [31:0] m;
        case (n)
            3'd1:    m = 32'h0000_00FF;
            3'd2:    m = 32'h0000_FFFF;
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbiter sharing one byte-wide single-port RAM between instruction
// fetch and load/store, moving one byte per cycle.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_we,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);

    state_t            state, state_nx;
    logic [2:0]        cnt, cnt_nx;
    logic [2:0]        n_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;
    logic [31:0]       wr_word;
    logic [31:0]       buf_r;
    logic [31:0]       asm_nx;
    logic              fetch_r;
    logic              rd_state;
    logic              grant;

    assign rd_state = (state == IF_RD) || (state == MEM_RD);
    assign grant    = (state == IDLE) && (mem_req || if_req);
    assign wr_word  = wdata_r >> {cnt[1:0], 3'b000};

    // State and byte counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == ResetEnable) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Grant priority and per-byte sequencing.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                cnt_nx = 3'd0;
                if (mem_req) begin
                    state_nx = mem_we ? MEM_WR : MEM_RD;
                end else if (if_req) begin
                    state_nx = IF_RD;
                end
            end
            IF_RD, MEM_RD: begin
                if (cnt == n_r) begin
                    state_nx = DONE;
                    cnt_nx   = 3'd0;
                end else begin
                    cnt_nx = cnt + 3'd1;
                end
            end
            MEM_WR: begin
                if (cnt == n_r - 3'd1) begin
                    state_nx = DONE;
                    cnt_nx   = 3'd0;
                end else begin
                    cnt_nx = cnt + 3'd1;
                end
            end
            DONE: begin
                state_nx = IDLE;
                cnt_nx   = 3'd0;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 3'd0;
            end
        endcase
    end

    // RAM port drive and completion pulses.
    always_comb begin
        ram_a    = '0;
        ram_we   = 1'b0;
        ram_dout = 8'h00;
        if_done  = 1'b0;
        mem_done = 1'b0;
        unique case (state)
            IF_RD, MEM_RD: begin
                if (cnt < n_r) begin
                    ram_a = addr_r + ADDR_W'(cnt);
                end
            end
            MEM_WR: begin
                ram_we   = 1'b1;
                ram_a    = addr_r + ADDR_W'(cnt);
                ram_dout = wr_word[7:0];
            end
            DONE: begin
                if_done  = fetch_r;
                mem_done = !fetch_r;
            end
            default: ;
        endcase
    end

    // Transfer context latched at grant so a dropped request cannot disturb it.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == ResetEnable) begin
            fetch_r <= 1'b0;
            addr_r  <= '0;
            wdata_r <= 32'h0;
            n_r     <= 3'd0;
        end else if (grant) begin
            fetch_r <= !mem_req;
            addr_r  <= mem_req ? mem_addr : if_addr;
            wdata_r <= mem_wdata;
            n_r     <= mem_req ? len_bytes(mem_len) : 3'd4;
        end
    end

    // Previous cycle's RAM byte lands in slot cnt-1.
    always_comb begin
        asm_nx = buf_r;
        unique case (cnt)
            3'd1:    asm_nx[7:0]   = ram_din;
            3'd2:    asm_nx[15:8]  = ram_din;
            3'd3:    asm_nx[23:16] = ram_din;
            3'd4:    asm_nx[31:24] = ram_din;
            default: ;
        endcase
    end

    // Byte assembly and result registers, updated only on completion.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == ResetEnable) begin
            buf_r     <= 32'h0;
            if_data   <= 32'h0;
            mem_rdata <= 32'h0;
        end else if (state == IDLE) begin
            buf_r <= 32'h0;
        end else if (rd_state && (cnt != 3'd0)) begin
            buf_r <= asm_nx;
            if (cnt == n_r) begin
                if (state == IF_RD) begin
                    if_data <= asm_nx;
                end else begin
                    mem_rdata <= asm_nx & len_mask(n_r);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, contention,
// reset abort and randomized traffic against a byte-array model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_len;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic [31:0] ram_a;
    logic        ram_we;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din = 8'h00;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .if_data   (if_data),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_len   (mem_len),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_done  (mem_done),
        .mem_rdata (mem_rdata),
        .ram_a     (ram_a),
        .ram_we    (ram_we),
        .ram_dout  (ram_dout),
        .ram_din   (ram_din)
    );

    // Behavioural RAM seen by the DUT, and the bench's own reference copy.
    logic [7:0] ram    [logic [31:0]];
    logic [7:0] shadow [logic [31:0]];

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    function automatic logic [7:0] sh_rd(input logic [31:0] a);
        return shadow.exists(a) ? shadow[a] : 8'h00;
    endfunction

    always @(posedge clk) begin
        if (ram_we) ram[ram_a] = ram_dout;
        else        ram_din <= ram_rd(ram_a);
    end

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] last_if  = 32'h0;
    logic [31:0] last_mem = 32'h0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] b);
        ram[a]    = b;
        shadow[a] = b;
    endtask

    function automatic int nbytes(input logic [1:0] len);
        return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a,
                                               input int n);
        logic [31:0] w = 32'h0;
        for (int i = 0; i < n; i++) w[8*i +: 8] = sh_rd(a + 32'(i));
        return w;
    endfunction

    // One transaction from an IDLE cycle back to the following IDLE cycle.
    task automatic xfer(input bit is_mem, input bit we, input logic [1:0] len,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp, input int lat, input bit drop);
        int n;
        int cyc;
        bit seen;
        logic [31:0] ea;
        n = is_mem ? nbytes(len) : 4;
        @(negedge clk);
        if (is_mem) begin
            mem_req = 1'b1; mem_we = we; mem_len = len;
            mem_addr = addr; mem_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        @(posedge clk);
        seen = 1'b0;
        cyc  = 1;
        while (cyc <= lat + 4) begin
            #1;
            if (cyc <= n) begin
                ea = addr + 32'(cyc - 1);
                chk("ram_a", ram_a, ea);
                chk("ram_we", 32'(ram_we), 32'(is_mem && we));
                if (is_mem && we)
                    chk("ram_dout", 32'(ram_dout), 32'(wdata[8*(cyc-1) +: 8]));
            end else begin
                chk("ram_we_off", 32'(ram_we), 32'h0);
            end
            if (is_mem ? mem_done : if_done) begin
                seen = 1'b1;
                break;
            end
            chk("early_done", 32'(is_mem ? if_done : mem_done), 32'h0);
            if (drop && cyc == 2) begin
                if_req = 1'b0; mem_req = 1'b0;
            end
            @(posedge clk);
            cyc++;
        end
        chk("latency", seen ? 32'(cyc) : 32'h0, 32'(lat));
        if (!is_mem) begin
            chk("if_data", if_data, exp);
            chk("mem_rdata_kept", mem_rdata, last_mem);
            last_if = exp;
        end else if (!we) begin
            chk("mem_rdata", mem_rdata, exp);
            chk("if_data_kept", if_data, last_if);
            last_mem = exp;
        end else begin
            chk("st_rdata_kept", mem_rdata, last_mem);
            for (int i = 0; i < n; i++) shadow[addr + 32'(i)] = wdata[8*i +: 8];
        end
        if_req = 1'b0; mem_req = 1'b0;
        @(posedge clk);
        #1;
        chk("pulse_width", 32'({if_done, mem_done}), 32'h0);
        chk("idle_ram_a", ram_a, 32'h0);
    endtask

    typedef struct {
        bit          is_mem;
        bit          we;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cyc;
        int cm;
        int cf;
        bit k;
        bit we;
        bit drp;
        logic [1:0]  ln;
        logic [31:0] a;
        logic [31:0] wd;
        int n;

        vecs[0] = '{1'b0, 1'b0, 2'd0, 32'h0000_0100, 32'h0, 32'h0000_0513, 6};
        vecs[1] = '{1'b1, 1'b0, 2'd0, 32'h0000_0203, 32'h0, 32'h0000_00AB, 3};
        vecs[2] = '{1'b1, 1'b1, 2'd3, 32'h0000_0400, 32'hDEAD_BEEF, 32'h0, 5};
        vecs[3] = '{1'b1, 1'b0, 2'd3, 32'h0000_0400, 32'h0, 32'hDEAD_BEEF, 6};
        vecs[4] = '{1'b1, 1'b0, 2'd1, 32'h0000_0401, 32'h0, 32'h0000_ADBE, 4};
        vecs[5] = '{1'b1, 1'b0, 2'd2, 32'h0000_0400, 32'h0, 32'hDEAD_BEEF, 6};
        vecs[6] = '{1'b1, 1'b1, 2'd0, 32'h0000_0402, 32'h1234_5677, 32'h0, 2};
        vecs[7] = '{1'b1, 1'b0, 2'd3, 32'h0000_0400, 32'h0, 32'hDE77_BEEF, 6};
        vecs[8] = '{1'b1, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0, 32'h0000_1234, 4};

        poke(32'h100, 8'h13); poke(32'h101, 8'h05);
        poke(32'h102, 8'h00); poke(32'h103, 8'h00);
        poke(32'h203, 8'hAB);
        poke(32'hFFFF_FFFF, 8'h34); poke(32'h0, 8'h12);
        poke(32'h500, 8'h11); poke(32'h501, 8'h22);
        poke(32'h502, 8'h33); poke(32'h503, 8'h44);
        for (int i = 0; i < 20; i++) poke(32'h1000 + 32'(i), 8'($urandom));

        rst = ResetEnable;
        if_req = 1'b0; if_addr = 32'h0;
        mem_req = 1'b0; mem_we = 1'b0; mem_len = 2'd0;
        mem_addr = 32'h0; mem_wdata = 32'h0;
        #1;
        chk("rst_outs", 32'({if_done, mem_done, ram_we}), 32'h0);
        chk("rst_if_data", if_data, 32'h0);
        chk("rst_mem_rdata", mem_rdata, 32'h0);
        chk("rst_ram_a", ram_a, 32'h0);
        chk("rst_ram_dout", 32'(ram_dout), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = ResetDisable;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++)
            xfer(vecs[i].is_mem, vecs[i].we, vecs[i].len, vecs[i].addr,
                 vecs[i].wdata, vecs[i].exp, vecs[i].lat, 1'b0);

        // Simultaneous requests: load first, fetch right after its DONE.
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd3; mem_addr = 32'h500;
        if_req = 1'b1; if_addr = 32'h100;
        @(posedge clk);
        cm = 0; cf = 0;
        for (cyc = 1; cyc <= 20; cyc++) begin
            #1;
            chk("cont_we", 32'(ram_we), 32'h0);
            if (mem_done && cm == 0) begin
                cm = cyc;
                chk("cont_order", 32'(if_done), 32'h0);
                chk("cont_ld", mem_rdata, 32'h4433_2211);
                mem_req = 1'b0;
            end
            if (if_done) begin
                cf = cyc;
                chk("cont_if", if_data, 32'h0000_0513);
                break;
            end
            @(posedge clk);
        end
        last_mem = 32'h4433_2211;
        chk("cont_mem_lat", 32'(cm), 32'd6);
        chk("cont_if_lat", 32'(cf), 32'd13);
        if_req = 1'b0;
        @(posedge clk);
        #1;

        // Reset during a fetch at byte counter 2.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h100;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_pre_a", ram_a, 32'h102);
        #1;
        rst = ResetEnable;
        #1;
        chk("abort_ram_a", ram_a, 32'h0);
        chk("abort_if_data", if_data, 32'h0);
        chk("abort_mem_rdata", mem_rdata, 32'h0);
        chk("abort_we_done", 32'({ram_we, if_done, mem_done}), 32'h0);
        if_req = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("abort_no_done", 32'({if_done, mem_done}), 32'h0);
        end
        @(negedge clk);
        rst = ResetDisable;
        last_if = 32'h0; last_mem = 32'h0;
        @(posedge clk);
        #1;
        xfer(1'b0, 1'b0, 2'd0, 32'h100, 32'h0, 32'h0000_0513, 6, 1'b0);

        // Randomized traffic against the shadow model.
        for (int t = 0; t < 40; t++) begin
            k   = 1'($urandom_range(0, 2) != 0);
            we  = 1'($urandom_range(0, 1));
            drp = 1'($urandom_range(0, 1));
            ln  = 2'($urandom_range(0, 3));
            a   = 32'h1000 + 32'($urandom_range(0, 15));
            wd  = $urandom;
            if (!k) begin
                xfer(1'b0, 1'b0, 2'd0, a, 32'h0, model_load(a, 4), 6, drp);
            end else begin
                n = nbytes(ln);
                xfer(1'b1, we, ln, a, wd, we ? 32'h0 : model_load(a, n),
                     we ? n + 1 : n + 2, drp);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, width of all address ports.
REQ-002 clk  in  1  single system clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 if_req  in  1  instruction-fetch request; held until if_done.
REQ-005 if_addr  in  ADDR_W  fetch byte address.
REQ-006 if_done  out  1  one-cycle completion pulse for fetch.
REQ-007 if_data  out  32  fetched word, little-endian.
REQ-008 mem_req  in  1  load/store request; held until mem_done.
REQ-009 mem_we  in  1  1 = store, 0 = load.
REQ-010 mem_len  in  2  size: 0 = 1B, 1 = 2B, 3 = 4B; 2 is treated as 3.
REQ-011 mem_addr  in  ADDR_W  load/store byte address.
REQ-012 mem_wdata  in  32  store data; byte k = bits [8k+7:8k].
REQ-013 mem_done  out  1  one-cycle completion pulse for load/store.
REQ-014 mem_rdata  out  32  load data, zero-filled above mem_len bytes.
REQ-015 ram_a  out  ADDR_W  byte address to the single-port RAM.
REQ-016 ram_we  out  1  RAM write enable.
REQ-017 ram_dout  out  8  RAM write byte.
REQ-018 ram_din  in  8  RAM read byte; valid one cycle after ram_a is presented with ram_we=0.

Function
REQ-019 FSM states: IDLE, IF_RD, MEM_RD, MEM_WR, DONE.
REQ-020 Requests are sampled only in IDLE.
- mem_req wins over if_req (→ MEM_RD or MEM_WR).
- Otherwise if_req → IF_RD.
- With no request, the FSM stays in IDLE.
REQ-021 A granted transfer is never preempted; the other requester waits.
REQ-022 Byte counter c starts at 0 on entry to a busy state; N = 4 for fetch, or the byte count decoded from mem_len.
REQ-023 Read cycles (c = 0..N):
- ram_a = addr + c while c < N.
- ram_din is captured into byte c-1 while c ≥ 1.
- After c = N the FSM goes to DONE.
REQ-024 Write cycles (c = 0..N-1):
- ram_we = 1, ram_a = addr + c, ram_dout = wdata byte c.
- After c = N-1 the FSM goes to DONE.
REQ-025 In DONE the matching done output is 1 for exactly one cycle; the next state is always IDLE, and requests are not sampled in DONE.
REQ-026 Latency from the IDLE sampling edge to the done pulse:
- read: N+2 cycles (fetch = 6)
- write: N+1 cycles
REQ-027 Address increment wraps modulo 2^ADDR_W.
REQ-028 if_data and mem_rdata hold their value until the next completion on the same port; mem_rdata bytes ≥ N read 0.
REQ-029 A store sets mem_done but leaves mem_rdata unchanged.
REQ-030 ram_we = 0 in every state except MEM_WR; ram_a = 0 and ram_dout = 0 in IDLE and DONE.
REQ-031 A request that drops mid-transfer does not abort the transfer; the done pulse is still issued.

Reset
REQ-032 Asserting rst (low) immediately forces, independent of clk:
- state = IDLE, c = 0
- all outputs = 0, including if_data, mem_rdata and ram_we
REQ-033 Reset mid-transfer discards partial data and issues no done pulse; the first grant after release needs rst high at a clk edge.

Structure
REQ-034 The state encodings, mem_len codes and ResetEnable/ResetDisable polarity constants live in the shared config header.
REQ-035 The block is a single module with no sub-module; the byte-assembly register sits in the same module.

Verification
REQ-036 Fetch: if_addr=0x100, RAM[0x100..0x103] = 13,05,00,00 → if_data = 0x00000513, if_done on the 6th cycle after sampling, ram_we never 1.
REQ-037 Byte load: mem_len=0, mem_addr=0x203, RAM[0x203]=0xAB → mem_rdata = 0x000000AB, mem_done on the 3rd cycle.
REQ-038 Word store: mem_we=1, mem_len=3, addr=0x400, wdata=0xDEADBEEF → RAM writes EF,BE,AD,DE at 0x400..0x403 in consecutive cycles; mem_done on the 5th cycle.
REQ-039 Contention: if_req and mem_req rise together → load served first; fetch starts in the IDLE cycle after the load's DONE; no RAM cycle overlaps.
REQ-040 Wrap: halfword load at 0xFFFFFFFF → ram_a sequence 0xFFFFFFFF, 0x00000000.
REQ-041 Reset: rst low at read cycle c=2 → ram_a = 0 and state = IDLE with no clock edge; no done pulse; a fresh fetch after release completes normally.
